// File: rtl/dii_arb_pkg.sv
// dii_arb_pkg: shared types and constants for the DII packet arbiter and routers.
package dii_arb_pkg;
    typedef enum logic {IDLE, LOCKED} arb_state_t;
    localparam int DII_WIDTH = 16;
endpackage

// File: rtl/dii_packet_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, searching from ptr+1 and wrapping to 0.
module rr_pick #(
    parameter int PORTS = 2
) (
    input  logic [PORTS-1:0]         req,
    input  logic [$clog2(PORTS)-1:0] ptr,
    output logic [PORTS-1:0]         gnt,
    output logic [$clog2(PORTS)-1:0] idx
);
    localparam int IW = $clog2(PORTS);
    logic [IW-1:0] p;
    logic found;
    always_comb begin
        gnt = '0;
        idx = '0;
        p = '0;
        found = 1'b0;
        for (int k = 1; k <= PORTS; k++) begin
            p = IW'((int'(ptr) + k) % PORTS);
            if (!found && req[p]) begin
                found = 1'b1;
                idx = p;
                gnt[p] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dii_packet_arbiter.sv
// dii_packet_arbiter: packet-granular round-robin merge of PORTS DII channels onto one registered output.
// Define DII_ARB_PKT_CHECK_EN to add the sticky framing-error output err.
module dii_packet_arbiter
    import dii_arb_pkg::*;
#(
    parameter int PORTS = 2,
    parameter int WIDTH = DII_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORTS*WIDTH-1:0] in_data,
    input  logic [PORTS-1:0]       in_first,
    input  logic [PORTS-1:0]       in_last,
    input  logic [PORTS-1:0]       in_valid,
    output logic [PORTS-1:0]       in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_first,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef DII_ARB_PKT_CHECK_EN
    ,
    output logic                   err
`endif
);
    localparam int IW = $clog2(PORTS);

    arb_state_t st, nst;
    logic [IW-1:0] grant, ptr, pick, sel;
    logic [PORTS-1:0] pick_gnt;
    logic [WIDTH-1:0] flit [PORTS];
    logic accept, sel_valid, xfer;

    for (genvar i = 0; i < PORTS; i++) begin : g_unpack
        assign flit[i] = in_data[i*WIDTH +: WIDTH];
    end

    rr_pick #(.PORTS(PORTS)) u_pick (
        .req (in_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick)
    );

    assign accept    = !out_valid || out_ready;
    assign sel       = (st == LOCKED) ? grant : pick;
    assign sel_valid = (st == LOCKED) ? in_valid[grant] : |in_valid;
    assign xfer      = !rst && accept && sel_valid;

    always_ff @(posedge clk) begin
        if (rst)
            st <= IDLE;
        else
            st <= nst;
    end

    always_comb begin
        nst = st;
        if (xfer)
            nst = in_last[sel] ? IDLE : LOCKED;
    end

    // A locked port owns in_ready even while its valid is low, so a stalled source never loses its slot.
    always_comb begin
        in_ready = (rst || !accept) ? '0 : (st == LOCKED) ? PORTS'(1) << grant : pick_gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant <= '0;
            ptr   <= IW'(PORTS - 1);
        end else if (xfer) begin
            if (st == IDLE && !in_last[sel])
                grant <= pick;
            if (in_last[sel])
                ptr <= sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= sel_valid;
            if (sel_valid) begin
                out_data  <= flit[sel];
                out_first <= in_first[sel];
                out_last  <= in_last[sel];
            end
        end
    end

`ifdef DII_ARB_PKT_CHECK_EN
    // Framing error: first must mark exactly the flit that opens a packet.
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (xfer && (in_first[sel] == (st == LOCKED)))
            err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_dii_packet_arbiter.sv
// tb_dii_packet_arbiter: directed self-checking bench for dii_packet_arbiter with PORTS=4.
module tb_dii_packet_arbiter;
    typedef logic [17:0] flit_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_data = '0;
    logic [3:0]  in_first = '0, in_last = '0, in_valid = '0, in_ready;
    logic [15:0] out_data;
    logic        out_first, out_last, out_valid;
    logic        out_ready = 1'b1;
`ifdef DII_ARB_PKT_CHECK_EN
    logic        err;
`endif

    int n_tests = 0;
    int n_fail = 0;
    flit_t q [4][$];
    flit_t olog [$];
    flit_t exp_q [$];

    always #5 clk = ~clk;

    dii_packet_arbiter #(.PORTS(4), .WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DII_ARB_PKT_CHECK_EN
        ,
        .err       (err)
`endif
    );

    function automatic flit_t f(input logic first, input logic last, input logic [15:0] d);
        return {first, last, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = q[i].size() != 0;
            if (q[i].size() != 0)
                {in_first[i], in_last[i], in_data[i*16 +: 16]} = q[i][0];
        end
        #1;
    endtask

    // One clock: sample handshakes at the negedge, then retire accepted flits after the posedge.
    task automatic step();
        logic [3:0] xf;
        @(negedge clk);
        xf = in_valid & in_ready;
        if (out_valid && out_ready)
            olog.push_back({out_first, out_last, out_data});
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (xf[i])
                void'(q[i].pop_front());
        drive();
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, olog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s[%0d]", tag, i), (i < olog.size()) ? 32'(olog[i]) : 32'hdead, 32'(exp_q[i]));
        olog.delete();
        exp_q.delete();
    endtask

    initial begin
        // Test 1 stimulus is queued before reset releases so in_ready=0 under rst is observable.
        q[0] = '{f(1, 0, 16'h0A00), f(0, 0, 16'h0A01), f(0, 1, 16'h0A02)};
        q[1] = '{f(1, 0, 16'h1B00), f(0, 1, 16'h1B01)};
        drive();
        step();
        step();
        check("rst_in_ready", in_ready, 4'b0000);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_flags", {out_first, out_last}, 0);
`ifdef DII_ARB_PKT_CHECK_EN
        check("rst_err", err, 0);
`endif
        rst = 1'b0;
        #1;
        // Test 1: packet A holds the grant against a waiting port 1.
        check("t1_rdy_a0", in_ready, 4'b0001);
        step();
        check("t1_rdy_a1", in_ready, 4'b0001);
        step();
        check("t1_rdy_a2", in_ready, 4'b0001);
        step();
        check("t1_rdy_b0", in_ready, 4'b0010);
        for (int i = 0; i < 5; i++)
            step();
        exp_q = '{f(1, 0, 16'h0A00), f(0, 0, 16'h0A01), f(0, 1, 16'h0A02), f(1, 0, 16'h1B00), f(0, 1, 16'h1B01)};
        check_log("t1_out");
        // Test 2: single-flit packets alternate with no bubble; ptr=1 so port 0 goes first.
        for (int i = 0; i < 4; i++) begin
            q[0].push_back(f(1, 1, 16'h0100 + 16'(i)));
            q[1].push_back(f(1, 1, 16'h1100 + 16'(i)));
        end
        drive();
        for (int i = 0; i < 9; i++)
            step();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(f(1, 1, 16'h0100 + 16'(i)));
            exp_q.push_back(f(1, 1, 16'h1100 + 16'(i)));
        end
        check_log("t2_out");
        // Test 3: after reset all four ports are served 0,1,2,3,0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        q[0] = '{f(1, 1, 16'h0A00), f(1, 1, 16'h0A01)};
        q[1] = '{f(1, 1, 16'h1A00)};
        q[2] = '{f(1, 1, 16'h2A00)};
        q[3] = '{f(1, 1, 16'h3A00)};
        drive();
        for (int i = 0; i < 6; i++)
            step();
        exp_q = '{f(1, 1, 16'h0A00), f(1, 1, 16'h1A00), f(1, 1, 16'h2A00), f(1, 1, 16'h3A00), f(1, 1, 16'h0A01)};
        check_log("t3_out");
        // Test 4: output stall mid-packet freezes the output and all in_ready.
        q[0] = '{f(1, 0, 16'h0C00), f(0, 0, 16'h0C01), f(0, 0, 16'h0C02), f(0, 1, 16'h0C03)};
        drive();
        step();
        step();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_rdy", in_ready, 4'b0000);
            check("t4_stall_data", out_data, 16'h0C01);
            step();
        end
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++)
            step();
        exp_q = '{f(1, 0, 16'h0C00), f(0, 0, 16'h0C01), f(0, 0, 16'h0C02), f(0, 1, 16'h0C03)};
        check_log("t4_out");
        // Test 5: reset after the second flit of a 4-flit packet drops it.
        q[0] = '{f(1, 0, 16'h0D00), f(0, 0, 16'h0D01), f(0, 0, 16'h0D02), f(0, 1, 16'h0D03)};
        drive();
        step();
        step();
        rst = 1'b1;
        q[0].delete();
        q[1] = '{f(1, 0, 16'h1E00), f(0, 1, 16'h1E01)};
        drive();
        check("t5_rst_rdy", in_ready, 4'b0000);
        step();
        check("t5_out_valid", out_valid, 0);
        check("t5_out_data", out_data, 0);
        check("t5_out_flags", {out_first, out_last}, 0);
        olog.delete();
        rst = 1'b0;
        #1;
        check("t5_rdy_e0", in_ready, 4'b0010);
        for (int i = 0; i < 3; i++)
            step();
        exp_q = '{f(1, 0, 16'h1E00), f(0, 1, 16'h1E01)};
        check_log("t5_out");
`ifdef DII_ARB_PKT_CHECK_EN
        // Test 6: a first flag inside an open packet sets the sticky error.
        check("t6_err_pre", err, 0);
        q[0] = '{f(1, 0, 16'h0F00), f(1, 0, 16'h0F01), f(0, 1, 16'h0F02)};
        drive();
        step();
        check("t6_err_ok", err, 0);
        step();
        check("t6_err_set", err, 1);
        for (int i = 0; i < 3; i++)
            step();
        check("t6_err_hold", err, 1);
        exp_q = '{f(1, 0, 16'h0F00), f(1, 0, 16'h0F01), f(0, 1, 16'h0F02)};
        check_log("t6_out");
        rst = 1'b1;
        step();
        check("t6_err_clr", err, 0);
        rst = 1'b0;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
